halt_reporter: RTL and testbench



---
 rtl/halt_reporter_pkg.sv | 28 ++
 rtl/halt_reporter_nibble_to_ascii.sv | 13 +
 rtl/halt_reporter.sv | 154 +++++++++++++++
 tb/tb_halt_reporter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/halt_reporter_pkg.sv
// halt_reporter_pkg: processor-wide constants shared with the halt reporter.
// Halt opcode, expected result values, status-line glyphs and FSM states.
package halt_reporter_pkg;

  localparam logic [5:0]  HALT_OPCODE = 6'h3F;

  localparam logic [31:0] EXP_R9    = 32'd55;
  localparam logic [31:0] EXP_DM576 = 32'd987;
  localparam logic [31:0] EXP_DM900 = 32'd97;
  localparam logic [31:0] EXP_DM532 = 32'h315;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_G     = 8'h47;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_SEND,
    ST_DONE
  } hr_state_e;

endpackage

// File: rtl/halt_reporter_nibble_to_ascii.sv
// nibble_to_ascii: 4-bit value to uppercase hex ASCII digit.
// Purely combinational.
module nibble_to_ascii (
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  always_comb begin
    chr = 8'h30 + {4'h0, nib};
    if (nib > 4'd9) chr = 8'h37 + {4'h0, nib};
  end

endmodule

// File: rtl/halt_reporter.sv
// halt_reporter: counts cycles to program halt, then writes a 16-char
// status line (hex count, pass flags, OK/NG) into the display buffer.
module halt_reporter
  import halt_reporter_pkg::*;
#(
  parameter logic [5:0] LINE_BASE  = 6'd0,
  parameter logic [5:0] HALT_OP    = HALT_OPCODE,
  parameter logic [7:0] CLEAR_CHAR = CH_COMMA
) (
  input  logic        sysclk,
  input  logic        cpu_reset,
  input  logic [5:0]  op_w,
  input  logic [31:0] r9,
  input  logic [31:0] dm576,
  input  logic [31:0] dm900,
  input  logic [31:0] dm532,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        halted,
  output logic        done,
  output logic [31:0] total_count
);

  hr_state_e   state;
  logic [3:0]  idx;
  logic [31:0] count;
  logic [31:0] r9_q, dm576_q, dm900_q, dm532_q;

  logic        live;
  logic        halt_now;
  logic [31:0] cnt_inc;
  logic [31:0] tot_n;
  logic [3:0]  pass_v;
  logic        pass_all;
  logic [3:0]  sel;
  logic [1:0]  fsel;
  logic [3:0]  nib;
  logic [7:0]  hex_char;
  logic [7:0]  line_char;

  assign live     = (state == ST_CLEAR) || (state == ST_RUN);
  assign halt_now = live && !halted && (op_w == HALT_OP);
  assign cnt_inc  = (count == '1) ? count : count + 32'd1;

  // On the halt edge itself the line is built from the values being latched.
  assign tot_n = halt_now ? cnt_inc : total_count;
  assign pass_v[0] = (halt_now ? r9    : r9_q)    == EXP_R9;
  assign pass_v[1] = (halt_now ? dm576 : dm576_q) == EXP_DM576;
  assign pass_v[2] = (halt_now ? dm900 : dm900_q) == EXP_DM900;
  assign pass_v[3] = (halt_now ? dm532 : dm532_q) == EXP_DM532;
  assign pass_all  = &pass_v;

  assign sel  = (state == ST_SEND) ? idx + 4'd1 : 4'd0;
  assign fsel = sel[1:0] - 2'd1;
  assign nib  = tot_n[{~sel[2:0], 2'b00} +: 4];

  nibble_to_ascii u_hex (
    .nib (nib),
    .chr (hex_char)
  );

  always_comb begin
    line_char = CH_SPACE;
    unique case (1'b1)
      !sel[3]:                    line_char = hex_char;
      sel == 4'd8:                line_char = CH_SPACE;
      sel >= 4'd9 && sel <= 4'd12:
        line_char = pass_v[fsel] ? CH_PLUS : CH_MINUS;
      sel == 4'd13:               line_char = CH_SPACE;
      sel == 4'd14:               line_char = pass_all ? CH_O : CH_N;
      sel == 4'd15:               line_char = pass_all ? CH_K : CH_G;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state       <= ST_CLEAR;
      idx         <= 4'd0;
      count       <= 32'd0;
      halted      <= 1'b0;
      done        <= 1'b0;
      total_count <= 32'd0;
      r9_q        <= 32'd0;
      dm576_q     <= 32'd0;
      dm900_q     <= 32'd0;
      dm532_q     <= 32'd0;
      wr_en       <= 1'b0;
      wr_addr     <= LINE_BASE;
      wr_data     <= CLEAR_CHAR;
    end else begin
      if (live && !halted && op_w != HALT_OP) count <= cnt_inc;
      if (halt_now) begin
        halted      <= 1'b1;
        total_count <= cnt_inc;
        r9_q        <= r9;
        dm576_q     <= dm576;
        dm900_q     <= dm900;
        dm532_q     <= dm532;
      end
      unique case (state)
        ST_CLEAR: begin
          if (!wr_en) begin
            wr_en   <= 1'b1;
            idx     <= 4'd0;
            wr_addr <= LINE_BASE;
            wr_data <= CLEAR_CHAR;
          end else if (wr_ready) begin
            if (idx == 4'd15) begin
              idx     <= 4'd0;
              wr_addr <= LINE_BASE;
              if (halted || halt_now) begin
                state   <= ST_SEND;
                wr_data <= line_char;
              end else begin
                state <= ST_RUN;
                wr_en <= 1'b0;
              end
            end else begin
              idx     <= idx + 4'd1;
              wr_addr <= LINE_BASE + {2'b00, idx + 4'd1};
            end
          end
        end
        ST_RUN: begin
          if (halt_now) begin
            state   <= ST_SEND;
            wr_en   <= 1'b1;
            idx     <= 4'd0;
            wr_addr <= LINE_BASE;
            wr_data <= line_char;
          end
        end
        ST_SEND: begin
          if (wr_ready) begin
            if (idx == 4'd15) begin
              state <= ST_DONE;
              wr_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx     <= idx + 4'd1;
              wr_addr <= LINE_BASE + {2'b00, idx + 4'd1};
              wr_data <= line_char;
            end
          end
        end
        ST_DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halt_reporter.sv
// tb_halt_reporter: scoreboard bench for halt_reporter.
// Expected writes are queued at stimulus time and popped on each accept.
module tb_halt_reporter;

  localparam logic [5:0] BASE = 6'd60;
  localparam logic [5:0] HLT  = 6'h3F;

  logic        sysclk = 1'b0;
  logic        cpu_reset = 1'b1;
  logic [5:0]  op_w = 6'd0;
  logic [31:0] r9 = 32'd0;
  logic [31:0] dm576 = 32'd0;
  logic [31:0] dm900 = 32'd0;
  logic [31:0] dm532 = 32'd0;
  logic        wr_ready = 1'b1;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        halted;
  logic        done;
  logic [31:0] total_count;

  halt_reporter #(.LINE_BASE(BASE)) dut (
    .sysclk      (sysclk),
    .cpu_reset   (cpu_reset),
    .op_w        (op_w),
    .r9          (r9),
    .dm576       (dm576),
    .dm900       (dm900),
    .dm532       (dm532),
    .wr_ready    (wr_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .halted      (halted),
    .done        (done),
    .total_count (total_count)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  logic [13:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       stall_q = 1'b0;
  logic [5:0] st_addr = 6'd0;
  logic [7:0] st_data = 8'd0;
  logic [13:0] exp_w;

  // Inputs change just after posedge; the negedge sees what the next edge uses.
  always @(negedge sysclk) begin
    if (stall_q) begin
      chk("hold_en", wr_en, 1);
      chk("hold_addr", wr_addr, st_addr);
      chk("hold_data", wr_data, st_data);
    end
    if (wr_en) chk("done_early", done, 0);
    if (wr_en && wr_ready && !cpu_reset) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", sb.size(), 1);
      end else begin
        exp_w = sb.pop_front();
        chk("wr_addr", wr_addr, exp_w[13:8]);
        chk("wr_data", wr_data, exp_w[7:0]);
      end
    end
    stall_q = wr_en && !wr_ready && !cpu_reset;
    st_addr = wr_addr;
    st_data = wr_data;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push_ch(input int i, input logic [7:0] ch);
    logic [5:0] a;
    a = BASE + 6'(i);
    sb.push_back({a, ch});
  endtask

  task automatic push_line(input logic [31:0] tot, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] d);
    logic [3:0] nb;
    logic [7:0] ch;
    logic [3:0] ok;
    for (int i = 0; i < 8; i++) begin
      nb = 4'((tot >> (28 - 4 * i)) & 32'hF);
      ch = (nb < 4'd10) ? 8'h30 + 8'(nb) : 8'h41 + 8'(nb) - 8'd10;
      push_ch(i, ch);
    end
    push_ch(8, 8'h20);
    ok = {d == 32'h315, c == 32'd97, b == 32'd987, a == 32'd55};
    for (int i = 0; i < 4; i++) push_ch(9 + i, ok[i] ? 8'h2B : 8'h2D);
    push_ch(13, 8'h20);
    push_ch(14, (&ok) ? 8'h4F : 8'h4E);
    push_ch(15, (&ok) ? 8'h4B : 8'h47);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, BASE);
    chk({tag, "_wr_data"}, wr_data, 8'h2C);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_total"}, total_count, 0);
  endtask

  task automatic do_reset();
    cpu_reset = 1'b1;
    op_w = 6'd0;
    wr_ready = 1'b1;
    tick();
    tick();
    sb.delete();
    check_reset_vals("rst");
    cpu_reset = 1'b0;
    for (int i = 0; i < 16; i++) push_ch(i, 8'h2C);
  endtask

  task automatic set_vals(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    r9 = a;
    dm576 = b;
    dm900 = c;
    dm532 = d;
  endtask

  task automatic halt_now(input logic [31:0] tot);
    op_w = HLT;
    push_line(tot, r9, dm576, dm900, dm532);
    tick();
    op_w = 6'd0;
    // Inputs change after the latch edge; the line must not follow them.
    set_vals(0, 0, 0, 0);
  endtask

  task automatic drain(input int maxc, input bit toggle);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      if (toggle) wr_ready = pat[n % 4];
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    wr_ready = 1'b1;
  endtask

  initial begin
    int n;

    // No halt: only the clearing pass.
    do_reset();
    tick();
    chk("clear_first_en", wr_en, 1);
    chk("clear_first_addr", wr_addr, BASE);
    repeat (16) tick();
    chk("clear_len", sb.size(), 0);
    chk("clear_end_en", wr_en, 0);
    repeat (5) tick();
    chk("idle_done", done, 0);
    chk("idle_halted", halted, 0);

    // All pass, halt after 99 counted cycles.
    do_reset();
    set_vals(55, 987, 97, 32'h315);
    repeat (99) tick();
    halt_now(32'd100);
    chk("run_halted", halted, 1);
    chk("run_total", total_count, 100);
    chk("run_first_en", wr_en, 1);
    chk("run_first_addr", wr_addr, BASE);
    chk("run_first_data", wr_data, 8'h30);
    drain(40, 1'b0);
    chk("run_done", done, 1);
    chk("run_done_en", wr_en, 0);
    op_w = HLT;
    tick();
    op_w = 6'd0;
    repeat (3) tick();
    chk("run_total_kept", total_count, 100);
    chk("run_done_sticky", done, 1);

    // One failing check and hex letters in the count.
    do_reset();
    set_vals(55, 987, 96, 32'h315);
    repeat (2748) tick();
    halt_now(32'd2749);
    chk("ng_total", total_count, 32'hABD);
    drain(40, 1'b0);
    chk("ng_done", done, 1);

    // Stalling ready pattern during the line.
    do_reset();
    set_vals(55, 0, 97, 32'h315);
    repeat (40) tick();
    halt_now(32'd41);
    drain(100, 1'b1);
    chk("stall_done", done, 1);

    // Halt inside the clearing pass, second halt ignored.
    do_reset();
    set_vals(55, 987, 97, 32'h315);
    repeat (2) tick();
    halt_now(32'd3);
    chk("clr_halted", halted, 1);
    chk("clr_total", total_count, 3);
    repeat (9) tick();
    op_w = HLT;
    tick();
    op_w = 6'd0;
    chk("clr_total_kept", total_count, 3);
    drain(60, 1'b0);
    chk("clr_done", done, 1);
    repeat (4) tick();
    chk("clr_no_extra", sb.size(), 0);

    // Reset while index 5 of the line is pending.
    do_reset();
    set_vals(55, 987, 97, 32'h315);
    repeat (30) tick();
    halt_now(32'd31);
    n = 0;
    while (sb.size() != 11 && n < 60) begin
      tick();
      n++;
    end
    chk("abort_wait", sb.size(), 11);
    cpu_reset = 1'b1;
    tick();
    check_reset_vals("abort");
    sb.delete();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
